// File: rtl/candidate_seq_ctrl_if.sv
// Host/adder-side signal bundle for the candidate job sequencer.
// The slave modport is the sequencer; the master modport is the host plus adder.
interface candidate_seq_ctrl_if;
    logic       start;
    logic [1:0] mode;
    logic [5:0] len;
    logic       abort;
    logic [7:0] candidate;
    logic       en;
    logic       count;
    logic [1:0] reg_mode;
    logic [5:0] now_0;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [7:0] cand_out;

    modport slave (
        input  start, mode, len, abort, candidate,
        output en, count, reg_mode, now_0, busy, done, aborted, cand_out
    );

    modport master (
        output start, mode, len, abort, candidate,
        input  en, count, reg_mode, now_0, busy, done, aborted, cand_out
    );
endinterface

// File: rtl/candidate_seq_ctrl.sv
// Job sequencer for the candidate adder: clear, run N steps, capture the total.
// Latency start->done is steps+3 cycles; start is ignored while busy, abort cancels any active job.
module candidate_seq_ctrl #(
    parameter int FIRST_IDX = 2,
    parameter int MAX_STEPS = 62
) (
    input  logic                clk,
    input  logic                rst,
    candidate_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, CAP} state_t;

    localparam logic [5:0] FIRST6 = 6'(FIRST_IDX);
    localparam logic [5:0] MAX6   = 6'(MAX_STEPS);

    state_t     r_state;
    logic [5:0] r_steps;
    logic [5:0] r_left;
    logic       r_en;
    logic       r_count;
    logic [1:0] r_reg_mode;
    logic [5:0] r_now_0;
    logic       r_busy;
    logic       r_done;
    logic       r_aborted;
    logic [7:0] r_cand_out;

    logic [5:0] w_len_clamped;
    logic       w_abort_taken;

    assign w_len_clamped = (bus.len > MAX6) ? MAX6 : bus.len;
    assign w_abort_taken = bus.abort && (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_steps    <= '0;
            r_left     <= '0;
            r_en       <= 1'b0;
            r_count    <= 1'b0;
            r_reg_mode <= '0;
            r_now_0    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
            r_cand_out <= '0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            if (w_abort_taken) begin
                r_state   <= IDLE;
                r_en      <= 1'b0;
                r_count   <= 1'b0;
                r_now_0   <= '0;
                r_busy    <= 1'b0;
                r_aborted <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.start) begin
                            r_reg_mode <= bus.mode;
                            r_steps    <= w_len_clamped;
                            r_busy     <= 1'b1;
                            r_state    <= LOAD;
                        end
                    end
                    LOAD: begin
                        if (r_steps != '0) begin
                            r_en    <= 1'b1;
                            r_count <= 1'b1;
                            r_now_0 <= FIRST6;
                            r_left  <= r_steps - 6'd1;
                            r_state <= RUN;
                        end else begin
                            r_state <= CAP;
                        end
                    end
                    RUN: begin
                        r_count <= 1'b0;
                        if (r_left == '0) begin
                            r_en    <= 1'b0;
                            r_now_0 <= '0;
                            r_state <= CAP;
                        end else begin
                            r_now_0 <= r_now_0 + 6'd1;
                            r_left  <= r_left - 6'd1;
                        end
                    end
                    CAP: begin
                        // Total is final here; the adder clears itself this edge since en=0.
                        r_cand_out <= bus.candidate;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.en       = r_en;
    assign bus.count    = r_count;
    assign bus.reg_mode = r_reg_mode;
    assign bus.now_0    = r_now_0;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.aborted  = r_aborted;
    assign bus.cand_out = r_cand_out;
endmodule

// File: tb/tb_candidate_seq_ctrl.sv
// Bench for candidate_seq_ctrl: a toy adder adds a random per-step increment while en=1,
// and each job is checked against a cycle timeline derived from the job's step count.
module tb_candidate_seq_ctrl;
    localparam int FIRST = 2;
    localparam int MAXS  = 62;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] exp_cand = 8'd0;
    logic [7:0] incs [0:63];
    logic [7:0] r_total;

    candidate_seq_ctrl_if bus ();

    candidate_seq_ctrl #(.FIRST_IDX(FIRST), .MAX_STEPS(MAXS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in adder: total clears when en=0, otherwise adds the increment for this step.
    always @(posedge clk) begin
        if (rst || !bus.en) r_total <= 8'd0;
        else                r_total <= r_total + incs[(int'(bus.now_0) - FIRST) & 63];
    end
    assign bus.candidate = r_total;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // c counts cycles after the start was accepted.
    task automatic check_cycle(input int c, input int s, input logic [1:0] m, input logic [7:0] nw);
        bit run, act, dn;
        run = (c >= 2) && (c <= 1 + s);
        act = (c <= 2 + s);
        dn  = (c == 3 + s);
        chk("en", 32'(bus.en), 32'(run));
        chk("busy", 32'(bus.busy), 32'(act));
        chk("done", 32'(bus.done), 32'(dn));
        chk("aborted", 32'(bus.aborted), 32'd0);
        chk("cand_out", 32'(bus.cand_out), dn ? 32'(nw) : 32'(exp_cand));
        if (run) begin
            chk("now_0", 32'(bus.now_0), 32'(FIRST + c - 2));
            chk("count", 32'(bus.count), 32'(c == 2));
        end
        if (act) chk("reg_mode", 32'(bus.reg_mode), 32'(m));
    endtask

    task automatic run_job(input logic [1:0] m, input logic [5:0] l, input int abort_c, input int start_c);
        int s;
        logic [7:0] nw;
        s  = (int'(l) > MAXS) ? MAXS : int'(l);
        nw = 8'd0;
        for (int i = 0; i < 64; i++) begin
            incs[i] = 8'($urandom_range(255, 0));
            if (i < s) nw = nw + incs[i];
        end
        bus.start = 1'b1; bus.mode = m; bus.len = l;
        tick();
        bus.start = 1'b0; bus.mode = ~m; bus.len = 6'd0;
        for (int c = 1; c <= 3 + s; c++) begin
            check_cycle(c, s, m, nw);
            if (c == 3 + s) begin
                exp_cand = nw;
                return;
            end
            if (c == abort_c) begin
                bus.abort = 1'b1;
                tick();
                bus.abort = 1'b0;
                chk("ab_pulse", 32'(bus.aborted), 32'd1);
                chk("ab_busy", 32'(bus.busy), 32'd0);
                chk("ab_en", 32'(bus.en), 32'd0);
                chk("ab_done", 32'(bus.done), 32'd0);
                chk("ab_cand", 32'(bus.cand_out), 32'(exp_cand));
                tick();
                chk("ab_pulse_end", 32'(bus.aborted), 32'd0);
                chk("ab_no_done", 32'(bus.done), 32'd0);
                return;
            end
            bus.start = (c == start_c);
            tick();
            bus.start = 1'b0;
        end
    endtask

    initial begin
        int s;
        int ab;
        logic [1:0] m;
        logic [5:0] l;
        bus.start = 1'b0; bus.mode = 2'd0; bus.len = 6'd0; bus.abort = 1'b0;
        for (int i = 0; i < 64; i++) incs[i] = 8'd0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_en", 32'(bus.en), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_cand", 32'(bus.cand_out), 32'd0);
        chk("rst_now0", 32'(bus.now_0), 32'd0);
        chk("rst_mode", 32'(bus.reg_mode), 32'd0);

        run_job(2'b00, 6'd3, -1, -1);
        tick();
        chk("done_1cyc", 32'(bus.done), 32'd0);
        run_job(2'b01, 6'd4, -1, 3);           // spurious start mid-RUN
        tick();
        run_job(2'b11, 6'd5, -1, -1);
        run_job(2'b10, 6'd2, -1, -1);          // accepted in the done cycle
        tick();
        run_job(2'b00, 6'd0, -1, -1);
        tick();
        run_job(2'b00, 6'd63, -1, -1);         // clamped to MAXS steps
        tick();
        run_job(2'b01, 6'd10, 4, -1);          // abort on step 2
        run_job(2'b10, 6'd6, 8, -1);           // abort during CAP
        run_job(2'b11, 6'd1, -1, -1);

        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("idle_abort", 32'(bus.aborted), 32'd0);
        chk("idle_abort_busy", 32'(bus.busy), 32'd0);

        for (int j = 0; j < 12; j++) begin
            m  = 2'($urandom_range(3, 0));
            l  = 6'($urandom_range(63, 0));
            s  = (int'(l) > MAXS) ? MAXS : int'(l);
            ab = ($urandom_range(3, 0) == 0) ? int'($urandom_range(2 + s, 1)) : -1;
            run_job(m, l, ab, -1);
            for (int g = $urandom_range(2, 0); g > 0; g--) tick();
        end

        bus.start = 1'b1; bus.mode = 2'b01; bus.len = 6'd10;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        exp_cand = 8'd0;
        chk("mid_rst_en", 32'(bus.en), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_cand", 32'(bus.cand_out), 32'(exp_cand));
        chk("mid_rst_now0", 32'(bus.now_0), 32'd0);
        chk("mid_rst_count", 32'(bus.count), 32'd0);
        chk("mid_rst_mode", 32'(bus.reg_mode), 32'd0);
        tick();
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        chk("mid_rst_abort", 32'(bus.aborted), 32'd0);
        chk("mid_rst_idle", 32'(bus.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/candidate_seq_ctrl.md
Name: candidate_seq_ctrl

Overview:
Job sequencer for the candidate-accumulation datapath (the CandidateAdder block). It accepts a job (mode, step count) from the host over a start/done handshake. It clears the adder, then drives en/count/reg_mode/now_0 for exactly the requested number of steps. It captures the final 8-bit candidate total into a holding register for the host. It sits between the top-level control and the adder; the result_0..2 streams go directly from the comparators to the adder and do not pass through this block.

Parameters:
FIRST_IDX, 2, now_0 value on the first step of a job (the adder treats now_0==FIRST_IDX as single-term in mode 00)
MAX_STEPS, 62, max steps per job; FIRST_IDX+MAX_STEPS-1 must fit in 6 bits

Ports:
clk  input  1  clock; all flops on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  job request; sampled only in IDLE
mode  input  2  job mode, latched on accepted start
len  input  6  step count, latched on accepted start
abort  input  1  cancel current job; effective in LOAD/RUN/CAP
candidate  input  8  registered total from adder
en  output  1  adder enable; 0 clears adder total at next edge
count  output  1  adder pair-phase flag
reg_mode  output  2  adder mode
now_0  output  6  adder step index
busy  output  1  job in progress
done  output  1  one-cycle pulse; cand_out valid
aborted  output  1  one-cycle pulse after abort taken
cand_out  output  8  final candidate of last completed job

Behaviour:
- Reset (rst=1 at an edge, synchronous): state=IDLE, en=0, count=0, reg_mode=0, now_0=0, busy=0, done=0, aborted=0, cand_out=0. Reset mid-job drops the job silently: no done, no aborted.
- All outputs are decoded from registered state/counters only (Moore); no combinational path from any input to any output.
- FSM states: IDLE, LOAD, RUN, CAP.
- IDLE: en=0, busy=0. When start=1: latch reg_mode<=mode, steps<=min(len, MAX_STEPS), go LOAD. start while busy is ignored; it is not queued.
- LOAD (1 cycle): en=0, busy=1; the adder total clears to 0 at the end of this cycle. Go RUN if steps>0, else CAP.
- RUN (steps cycles): en=1, busy=1. Step k (k=0..steps-1): now_0=FIRST_IDX+k, count=1 when k=0, else 0. (k=0 has no valid previous result_2 in the adder's tmp.) After step steps-1, go CAP.
- CAP (1 cycle): en=0, busy=1; candidate now holds the final total. At the end of the cycle: cand_out<=candidate, done<=1, go IDLE. The adder self-clears because en=0.
- Latency: start accepted at cycle T (in IDLE) -> done=1, busy=0 and cand_out valid in cycle T+3+steps. len=0 -> done at T+3 with cand_out=0.
- A new start is accepted in the done cycle (state is IDLE). cand_out holds until the next done or reset.
- abort=1 in LOAD/RUN/CAP: go IDLE next edge, en=0, aborted=1 for 1 cycle, done=0, cand_out unchanged. Abort in the same cycle as CAP: abort wins, no capture. abort in IDLE: no effect.
- len>MAX_STEPS is clamped to MAX_STEPS; now_0 never exceeds FIRST_IDX+MAX_STEPS-1 and never wraps.
- Arithmetic: step counter is 6 bits, unsigned. The candidate total is 8-bit modulo in the adder; the controller does no overflow detection.

Test Plan:
- Reset: hold rst 2 cycles mid-RUN -> next cycle all outputs 0, state IDLE, no done/aborted pulse.
- Mode 00, len=3, results=111 every step -> now_0 sequence 2,3,4; en high 3 cycles; done at T+6; cand_out=1+3+3=7.
- Mode 01, len=4, results=111 every step -> count sequence 1,0,0,0; cand_out=1+2+2+2=7.
- Mode 11, len=5, results=110 every step -> cand_out=5. Then start in the done cycle with mode 10, len=2, results=100 -> accepted; cand_out=1+1=2.
- len=0 -> no en pulse, done at T+3, cand_out=0. len=63 -> clamped to 62 steps, last now_0=63, done at T+65.
- abort on step 2 of a len=10 job -> aborted pulse, no done, cand_out keeps its previous value. start during RUN -> ignored. abort asserted in CAP -> no capture.
